sm_clk_gen: RTL and testbench

- Parametrised successor to the tunable clock divider. Generates a registered, glitch-free slow CPU clock from the board clock.
- Modes: free-run, halt, and single-step. Step is a debug feature for stepping the core one clock at a time.
- Contains its own input synchronisers and step edge detection.
- Sits in the hardware top level between the board clock/switches and every block clocked by the CPU clock.

---
 rtl/sm_clk_gen.sv | 171 +++++++++++++++++
 tb/tb_sm_clk_gen.sv | 121 ++++++++++++
 2 files changed

// File: rtl/sm_clk_gen.sv
// Glitch-free divided CPU clock generator with free-run, halt and single-step modes.
// Single-step support is built only when SM_CONFIG_CLK_GEN_STEP_EN is defined.
module sm_clk_gen #(
  parameter int unsigned SHIFT       = 16,
  parameter int unsigned DIV_W       = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clkIn,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] divide,
  input  logic             enable,
  input  logic             step,
  output logic             clkOut,
  output logic             tick,
  output logic             running
);

  typedef enum logic [1:0] {
    S_HALT    = 2'd0,
    S_RUN     = 2'd1,
    S_STEP_HI = 2'd2,
    S_STEP_LO = 2'd3
  } state_t;

  state_t                              r_state;
  logic [CNT_W-1:0]                    r_cnt;
  logic                                r_clk_out;
  logic                                r_tick;
  logic                                r_running;
  logic [DIV_W-1:0]                    r_div_l;
  logic [SYNC_STAGES-1:0]              r_en_sync;
  logic [SYNC_STAGES-1:0][DIV_W-1:0]   r_div_sync;

  state_t                              w_state_nxt;
  logic [CNT_W-1:0]                    w_cnt_nxt;
  logic                                w_clk_nxt;
  logic                                w_tick_nxt;
  logic [DIV_W-1:0]                    w_div_l_nxt;
  logic                                w_en_s;
  logic [DIV_W-1:0]                    w_div_s;
  logic [31:0]                         w_shamt;
  logic [CNT_W-1:0]                    w_term;
  logic                                w_term_hit;
  logic                                w_step_rise;

  assign w_en_s     = r_en_sync[SYNC_STAGES-1];
  assign w_div_s    = r_div_sync[SYNC_STAGES-1];
  assign w_shamt    = 32'(SHIFT) + 32'(r_div_l);
  assign w_term     = (CNT_W'(1) << w_shamt) - CNT_W'(1);
  assign w_term_hit = (r_cnt == w_term);

`ifdef SM_CONFIG_CLK_GEN_STEP_EN
  logic [SYNC_STAGES-1:0] r_step_sync;
  logic                   r_step_prev;

  // Step button synchroniser and rising-edge detector
  always_ff @(posedge clkIn) begin
    if (!rst_n) begin
      r_step_sync <= '0;
      r_step_prev <= 1'b0;
    end else begin
      r_step_sync <= {r_step_sync[SYNC_STAGES-2:0], step};
      r_step_prev <= r_step_sync[SYNC_STAGES-1];
    end
  end

  assign w_step_rise = r_step_sync[SYNC_STAGES-1] & ~r_step_prev;
`else
  logic w_unused_step;
  assign w_unused_step = step;
  assign w_step_rise   = 1'b0;
`endif

  // State, counter, output flops and switch synchronisers
  always_ff @(posedge clkIn) begin
    if (!rst_n) begin
      r_state    <= S_HALT;
      r_cnt      <= '0;
      r_clk_out  <= 1'b0;
      r_tick     <= 1'b0;
      r_running  <= 1'b0;
      r_div_l    <= '0;
      r_en_sync  <= '0;
      r_div_sync <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_clk_out  <= w_clk_nxt;
      r_tick     <= w_tick_nxt;
      r_running  <= (w_state_nxt != S_HALT);
      r_div_l    <= w_div_l_nxt;
      r_en_sync  <= {r_en_sync[SYNC_STAGES-2:0], enable};
      r_div_sync <= {r_div_sync[SYNC_STAGES-2:0], divide};
    end
  end

  // Next-state logic; a high half in RUN always completes before halting
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clk_nxt   = r_clk_out;
    unique case (r_state)
      S_HALT: begin
        w_cnt_nxt = '0;
        w_clk_nxt = 1'b0;
        if (w_en_s) begin
          w_state_nxt = S_RUN;
          w_clk_nxt   = 1'b1;
        end else if (w_step_rise) begin
          w_state_nxt = S_STEP_HI;
          w_clk_nxt   = 1'b1;
        end
      end
      S_RUN: begin
        if (!w_en_s && !r_clk_out) begin
          w_state_nxt = S_HALT;
          w_cnt_nxt   = '0;
        end else if (w_term_hit) begin
          w_cnt_nxt = '0;
          w_clk_nxt = ~r_clk_out;
          if (r_clk_out && !w_en_s) begin
            w_state_nxt = S_HALT;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
`ifdef SM_CONFIG_CLK_GEN_STEP_EN
      S_STEP_HI: begin
        if (w_term_hit) begin
          w_cnt_nxt   = '0;
          w_clk_nxt   = 1'b0;
          w_state_nxt = S_STEP_LO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_STEP_LO: begin
        if (w_term_hit) begin
          w_cnt_nxt = '0;
          if (w_en_s) begin
            w_state_nxt = S_RUN;
            w_clk_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_HALT;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
`endif
      default: begin
        w_state_nxt = S_HALT;
        w_cnt_nxt   = '0;
        w_clk_nxt   = 1'b0;
      end
    endcase
  end

  // Divide is only re-sampled on a clkOut edge so a half never changes length
  always_comb begin
    w_tick_nxt  = w_clk_nxt & ~r_clk_out;
    w_div_l_nxt = (w_clk_nxt != r_clk_out) ? w_div_s : r_div_l;
  end

  assign clkOut  = r_clk_out;
  assign tick    = r_tick;
  assign running = r_running;

endmodule

// File: tb/tb_sm_clk_gen.sv
// Scoreboard bench for sm_clk_gen: per-cycle expected {clkOut,tick,running} queued by
// the stimulus and popped by an independent monitor after each rising edge.
module tb_sm_clk_gen;

  localparam int unsigned DIV_W = 2;

  logic             clkIn = 1'b0;
  logic             rst_n = 1'b0;
  logic [DIV_W-1:0] divide = '0;
  logic             enable = 1'b1;
  logic             step = 1'b0;
  logic             clkOut;
  logic             tick;
  logic             running;

  typedef struct {
    logic [2:0] exp;
    string      tag;
    int         idx;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  sm_clk_gen #(
    .SHIFT      (0),
    .DIV_W      (DIV_W),
    .CNT_W      (8),
    .SYNC_STAGES(2)
  ) dut (
    .clkIn  (clkIn),
    .rst_n  (rst_n),
    .divide (divide),
    .enable (enable),
    .step   (step),
    .clkOut (clkOut),
    .tick   (tick),
    .running(running)
  );

  always #5 clkIn = ~clkIn;

  // Run sequence: enable, divide=1, divide->0 mid-high, divide=2, drop enable mid-high
  logic [2:0] run_exp [26] = '{
    3'b000, 3'b000, 3'b111, 3'b101, 3'b001, 3'b001, 3'b111, 3'b101, 3'b001, 3'b001,
    3'b111, 3'b101, 3'b001, 3'b111, 3'b001, 3'b111, 3'b001, 3'b111, 3'b101, 3'b101,
    3'b101, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000
  };
  logic       step1_in  [9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       step2_in  [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef SM_CONFIG_CLK_GEN_STEP_EN
  logic [2:0] step1_exp [9]  = '{3'b000, 3'b000, 3'b111, 3'b101, 3'b001, 3'b001,
                                 3'b000, 3'b000, 3'b000};
  logic [2:0] step2_exp [10] = '{3'b000, 3'b000, 3'b111, 3'b101, 3'b001, 3'b001,
                                 3'b000, 3'b000, 3'b000, 3'b000};
`else
  logic [2:0] step1_exp [9]  = '{default: 3'b000};
  logic [2:0] step2_exp [10] = '{default: 3'b000};
`endif

  task automatic apply(input logic rn, input logic en, input logic st,
                       input logic [DIV_W-1:0] dv, input logic [2:0] ex,
                       input string tag, input int idx);
    exp_t e;
    @(negedge clkIn);
    rst_n  = rn;
    enable = en;
    step   = st;
    divide = dv;
    e.exp  = ex;
    e.tag  = tag;
    e.idx  = idx;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs after each rising edge are compared to the oldest expectation
  initial begin
    exp_t       e;
    logic [2:0] act;
    forever begin
      @(posedge clkIn);
      #1;
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = {clkOut, tick, running};
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s[%0d]: {clkOut,tick,running} got %b expected %b",
                   e.tag, e.idx, act, e.exp);
        end
      end
    end
  end

  initial begin
    logic [DIV_W-1:0] dv;
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 1'b0, 2'd0, 3'b000, "reset", i);
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b0, 2'd1, 3'b000, "idle", i);
    for (int i = 0; i < 26; i++) begin
      dv = (i < 10) ? 2'd1 : (i < 15) ? 2'd0 : 2'd2;
      apply(1'b1, (i < 17), 1'b0, dv, run_exp[i], "run", i);
    end
    for (int i = 0; i < 9; i++)
      apply(1'b1, 1'b0, step1_in[i], 2'd1, step1_exp[i], "step", i);
    for (int i = 0; i < 10; i++)
      apply(1'b1, 1'b0, step2_in[i], 2'd1, step2_exp[i], "step_twice", i);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clkIn);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
